// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: scans the transmit mailboxes for the highest bus-priority request,
// freezes its frame fields for the encapsulation unit and sequences start/ack/retry/abort.
module can_tx_scheduler #(
  parameter int NMB       = 4,
  parameter int IDXW      = 2,
  parameter int MAX_RETRY = 15
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NMB-1:0]    mb_req,
  input  logic [NMB-1:0]    mb_abort_req,
  input  logic [NMB*29-1:0] mb_id,
  input  logic [NMB-1:0]    mb_ext,
  input  logic [NMB-1:0]    mb_rem,
  input  logic [NMB*4-1:0]  mb_dlc,
  input  logic              bus_idle,
  input  logic              tx_done,
  input  logic              tx_lost,
  input  logic              tx_error,
  output logic [28:0]       enc_identifier,
  output logic              enc_extended,
  output logic              enc_remote,
  output logic [3:0]        enc_datalen,
  output logic              tx_start,
  output logic [IDXW-1:0]   tx_sel,
  output logic [NMB-1:0]    mb_ack,
  output logic [NMB-1:0]    mb_aborted,
  output logic              busy
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_LOAD,
    ST_WAIT_BUS,
    ST_ACTIVE
  } state_t;

  // Key mirrors the on-wire arbitration bit order, so a plain unsigned compare ranks frames.
  function automatic logic [31:0] arb_key(input logic [28:0] id, input logic ext,
                                          input logic rem);
    arb_key = {id[28:18], (ext ? 1'b1 : rem), ext, (ext ? id[17:0] : 18'd0), (ext & rem)};
  endfunction

  state_t          r_state;
  state_t          w_state_nxt;
  logic [IDXW-1:0] r_scan_idx;
  logic [IDXW-1:0] r_best_idx;
  logic [31:0]     r_best_key;
  logic            r_best_valid;
  logic [IDXW-1:0] r_sel;
  logic [7:0]      r_retry_cnt;
  logic [28:0]     r_enc_id;
  logic            r_enc_ext;
  logic            r_enc_rem;
  logic [3:0]      r_enc_dlc;
  logic            r_tx_start;
  logic [NMB-1:0]  r_mb_ack;
  logic [NMB-1:0]  r_mb_aborted;

  logic            w_scan_req;
  logic [31:0]     w_scan_key;
  logic            w_scan_hit;
  logic            w_scan_last;
  logic            w_sel_req;
  logic            w_sel_abort;
  logic [28:0]     w_best_id;
  logic            w_best_ext;
  logic            w_best_rem;
  logic [3:0]      w_best_dlc;
  logic [7:0]      w_cnt_inc;
  logic            w_retry_abort;
  logic [NMB-1:0]  w_sel_onehot;
  logic            w_tx_start_nxt;
  logic [NMB-1:0]  w_ack_nxt;
  logic [NMB-1:0]  w_aborted_nxt;

  // NOTE: every combinational output gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_scan_req  = 1'b0;
    w_scan_key  = '0;
    w_sel_req   = 1'b0;
    w_sel_abort = 1'b0;
    w_best_id   = '0;
    w_best_ext  = 1'b0;
    w_best_rem  = 1'b0;
    w_best_dlc  = '0;
    for (int i = 0; i < NMB; i++) begin
      if (r_scan_idx == IDXW'(i)) begin
        w_scan_req = mb_req[i];
        w_scan_key = arb_key(mb_id[29*i +: 29], mb_ext[i], mb_rem[i]);
      end
      if (r_sel == IDXW'(i)) begin
        w_sel_req   = mb_req[i];
        w_sel_abort = mb_abort_req[i];
      end
      if (r_best_idx == IDXW'(i)) begin
        w_best_id  = mb_id[29*i +: 29];
        w_best_ext = mb_ext[i];
        w_best_rem = mb_rem[i];
        w_best_dlc = mb_dlc[4*i +: 4];
      end
    end
  end

  assign w_scan_hit    = w_scan_req && (!r_best_valid || (w_scan_key < r_best_key));
  assign w_scan_last   = (r_scan_idx == IDXW'(NMB - 1));
  assign w_cnt_inc     = (r_retry_cnt == 8'hFF) ? 8'hFF : (r_retry_cnt + 8'd1);
  assign w_retry_abort = w_sel_abort || ((MAX_RETRY != 0) && (w_cnt_inc >= 8'(MAX_RETRY)));
  assign w_sel_onehot  = NMB'(1) << r_sel;

  always_comb begin
    w_state_nxt    = r_state;
    w_tx_start_nxt = 1'b0;
    w_ack_nxt      = '0;
    w_aborted_nxt  = '0;
    case (r_state)
      ST_IDLE: begin
        if (|mb_req) w_state_nxt = ST_SCAN;
      end
      ST_SCAN: begin
        if (w_scan_last) w_state_nxt = (r_best_valid || w_scan_hit) ? ST_LOAD : ST_IDLE;
      end
      ST_LOAD: begin
        w_state_nxt = ST_WAIT_BUS;
      end
      ST_WAIT_BUS: begin
        if (!w_sel_req) begin
          w_state_nxt = ST_IDLE;
        end else if (w_sel_abort) begin
          w_aborted_nxt = w_sel_onehot;
          w_state_nxt   = ST_IDLE;
        end else if (bus_idle) begin
          w_tx_start_nxt = 1'b1;
          w_state_nxt    = ST_ACTIVE;
        end
      end
      ST_ACTIVE: begin
        // A pending CPU abort only takes effect on an outcome; a frame on the wire is never cut.
        if (tx_done) begin
          w_ack_nxt   = w_sel_onehot;
          w_state_nxt = ST_IDLE;
        end else if (tx_lost || tx_error) begin
          if (w_retry_abort) w_aborted_nxt = w_sel_onehot;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: reset is synchronous, so it lives inside the clocked branch rather than the sensitivity list.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_tx_start   <= 1'b0;
      r_mb_ack     <= '0;
      r_mb_aborted <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_tx_start   <= w_tx_start_nxt;
      r_mb_ack     <= w_ack_nxt;
      r_mb_aborted <= w_aborted_nxt;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_scan_idx   <= '0;
      r_best_idx   <= '0;
      r_best_key   <= '0;
      r_best_valid <= 1'b0;
      r_sel        <= '0;
      r_retry_cnt  <= '0;
      r_enc_id     <= '0;
      r_enc_ext    <= 1'b0;
      r_enc_rem    <= 1'b0;
      r_enc_dlc    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_scan_idx   <= '0;
          r_best_valid <= 1'b0;
        end
        ST_SCAN: begin
          if (w_scan_hit) begin
            r_best_idx   <= r_scan_idx;
            r_best_key   <= w_scan_key;
            r_best_valid <= 1'b1;
          end
          r_scan_idx <= r_scan_idx + IDXW'(1);
        end
        ST_LOAD: begin
          r_enc_id  <= w_best_id;
          r_enc_ext <= w_best_ext;
          r_enc_rem <= w_best_rem;
          r_enc_dlc <= w_best_dlc;
          r_sel     <= r_best_idx;
          // Retry history belongs to the last attempted mailbox only.
          if (r_best_idx != r_sel) r_retry_cnt <= '0;
        end
        ST_ACTIVE: begin
          if (tx_done) begin
            r_retry_cnt <= '0;
          end else if (tx_lost || tx_error) begin
            r_retry_cnt <= w_retry_abort ? 8'd0 : w_cnt_inc;
          end
        end
        default: ;
      endcase
    end
  end

  assign enc_identifier = r_enc_id;
  assign enc_extended   = r_enc_ext;
  assign enc_remote     = r_enc_rem;
  assign enc_datalen    = r_enc_dlc;
  assign tx_start       = r_tx_start;
  assign tx_sel         = r_sel;
  assign mb_ack         = r_mb_ack;
  assign mb_aborted     = r_mb_aborted;
  assign busy           = (r_state != ST_IDLE);

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: directed scenarios followed by randomized
// mailbox traffic compared against a transaction-level priority/retry model.
module tb_can_tx_scheduler;

  localparam int NMB       = 4;
  localparam int IDXW      = 2;
  localparam int MAX_RETRY = 3;
  localparam int LAT       = NMB + 3;

  logic              clock = 1'b0;
  logic              reset = 1'b1;
  logic [NMB-1:0]    mb_req = '0;
  logic [NMB-1:0]    mb_abort_req = '0;
  logic [NMB*29-1:0] mb_id = '0;
  logic [NMB-1:0]    mb_ext = '0;
  logic [NMB-1:0]    mb_rem = '0;
  logic [NMB*4-1:0]  mb_dlc = '0;
  logic              bus_idle = 1'b0;
  logic              tx_done = 1'b0;
  logic              tx_lost = 1'b0;
  logic              tx_error = 1'b0;

  logic [28:0]       enc_identifier;
  logic              enc_extended;
  logic              enc_remote;
  logic [3:0]        enc_datalen;
  logic              tx_start;
  logic [IDXW-1:0]   tx_sel;
  logic [NMB-1:0]    mb_ack;
  logic [NMB-1:0]    mb_aborted;
  logic              busy;

  int n_checks = 0;
  int n_err    = 0;
  int m_last_sel = 0;
  int m_cnt      = 0;

  can_tx_scheduler #(.NMB(NMB), .IDXW(IDXW), .MAX_RETRY(MAX_RETRY)) dut (
    .clock(clock), .reset(reset), .mb_req(mb_req), .mb_abort_req(mb_abort_req),
    .mb_id(mb_id), .mb_ext(mb_ext), .mb_rem(mb_rem), .mb_dlc(mb_dlc),
    .bus_idle(bus_idle), .tx_done(tx_done), .tx_lost(tx_lost), .tx_error(tx_error),
    .enc_identifier(enc_identifier), .enc_extended(enc_extended), .enc_remote(enc_remote),
    .enc_datalen(enc_datalen), .tx_start(tx_start), .tx_sel(tx_sel), .mb_ack(mb_ack),
    .mb_aborted(mb_aborted), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [46:0] all_out;
  assign all_out = {enc_identifier, enc_extended, enc_remote, enc_datalen, tx_start,
                    tx_sel, mb_ack, mb_aborted, busy};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_mb(input int i, input logic [28:0] id, input logic ext,
                        input logic rem, input logic [3:0] dlc);
    mb_id[29*i +: 29] = id;
    mb_ext[i]         = ext;
    mb_rem[i]         = rem;
    mb_dlc[4*i +: 4]  = dlc;
  endtask

  // Bus priority from CAN arbitration rules: base id, SRR/RTR, IDE, extended id, RTR.
  function automatic longint ref_key(input int i);
    logic [28:0] id;
    longint k;
    id = mb_id[29*i +: 29];
    k  = longint'(id >> 18) * (longint'(1) << 21);
    if (mb_ext[i]) k = k + (longint'(1) << 20) + (longint'(1) << 19) +
                       longint'(id % (1 << 18)) * 2 + longint'(mb_rem[i]);
    else           k = k + longint'(mb_rem[i]) * (longint'(1) << 20);
    return k;
  endfunction

  function automatic int ref_winner();
    int best;
    best = -1;
    for (int i = 0; i < NMB; i++)
      if (mb_req[i] && (best < 0 || ref_key(i) < ref_key(best))) best = i;
    return best;
  endfunction

  // Model of the retry history: a new selection starts a fresh count.
  task automatic model_select(input int w);
    if (w != m_last_sel) m_cnt = 0;
    m_last_sel = w;
  endtask

  task automatic wait_start(input string tag, input int raise_at, output int lat);
    int exp_lat;
    exp_lat  = (raise_at + 1 > LAT) ? raise_at + 1 : LAT;
    lat      = -1;
    bus_idle = (raise_at > 0) ? 1'b0 : 1'b1;
    for (int k = 1; k <= exp_lat + 10 && lat < 0; k++) begin
      tick();
      if (tx_start) lat = k;
      if (k == raise_at) bus_idle = 1'b1;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic check_sel(input string tag, input int w);
    logic [36:0] exp;
    exp = {IDXW'(w), mb_id[29*w +: 29], mb_ext[w], mb_rem[w], mb_dlc[4*w +: 4]};
    check(tag, {tx_sel, enc_identifier, enc_extended, enc_remote, enc_datalen}, exp);
  endtask

  task automatic done_tx(input string tag, input int w);
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check(tag, {busy, mb_ack, mb_aborted}, {1'b0, NMB'(1 << w), NMB'(0)});
    mb_req[w] = 1'b0;
    m_cnt = 0;
  endtask

  task automatic start_and_done(input string tag, input int w);
    int lat;
    model_select(w);
    wait_start(tag, 0, lat);
    check_sel({tag, "_sel"}, w);
    done_tx({tag, "_ack"}, w);
  endtask

  initial begin
    int lat;
    int starts;
    int w;
    int r;
    int n_hold;
    bit ab;
    bit d;
    logic [NMB-1:0] exp_ack;
    logic [NMB-1:0] exp_abt;
    logic [10:0] hi;

    tick();
    tick();
    check("reset_outputs", 64'(all_out), 64'd0);
    reset = 1'b0;
    tick();
    check("idle_no_request", {busy, tx_start}, 2'b00);

    // Single standard request
    set_mb(0, {11'h123, 18'h0}, 1'b0, 1'b0, 4'd8);
    mb_req = 4'b0001;
    start_and_done("single", 0);
    tick();
    check("single_ack_one_cycle", {busy, mb_ack, tx_start}, '0);

    // Priority ordering: lower base id wins, standard beats extended with same base
    set_mb(1, {11'h100, 18'h0}, 1'b0, 1'b0, 4'd1);
    set_mb(2, {11'h0FF, 18'h0}, 1'b0, 1'b0, 4'd2);
    set_mb(3, {11'h0FF, 18'h01234}, 1'b1, 1'b0, 4'd3);
    mb_req = 4'b1110;
    start_and_done("prio_a", 2);
    start_and_done("prio_b", 3);
    start_and_done("prio_c", 1);

    // Equal keys: lower index wins; data frame beats remote frame with the same id
    set_mb(0, {11'h200, 18'h0}, 1'b0, 1'b0, 4'd4);
    set_mb(3, {11'h200, 18'h0}, 1'b0, 1'b0, 4'd5);
    mb_req = 4'b1001;
    start_and_done("tie_a", 0);
    start_and_done("tie_b", 3);
    set_mb(1, {11'h300, 18'h0}, 1'b0, 1'b1, 4'd0);
    set_mb(2, {11'h300, 18'h0}, 1'b0, 1'b0, 4'd6);
    mb_req = 4'b0110;
    start_and_done("rtr_a", 2);
    start_and_done("rtr_b", 1);

    // Retry limit: the third lost arbitration aborts the mailbox
    set_mb(2, {11'h050, 18'h2AAAA}, 1'b1, 1'b0, 4'd7);
    mb_req = 4'b0100;
    for (int a = 0; a < MAX_RETRY; a++) begin
      wait_start("retry_start", 0, lat);
      check_sel("retry_sel", 2);
      tx_lost = 1'b1;
      tick();
      tx_lost = 1'b0;
      check("retry_outcome", {busy, mb_ack, mb_aborted},
            {1'b0, NMB'(0), (a == MAX_RETRY - 1) ? 4'b0100 : 4'b0000});
    end
    mb_req = '0;
    starts = 0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (tx_start) starts++;
    end
    check("retry_no_fourth_start", 64'(starts), 64'd0);

    // Abort requested while ACTIVE is deferred until an outcome
    set_mb(1, {11'h010, 18'h0}, 1'b0, 1'b0, 4'd2);
    mb_req = 4'b0010;
    wait_start("abort_active_start", 0, lat);
    mb_abort_req = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      tick();
      check("abort_active_deferred", {busy, mb_aborted}, {1'b1, 4'b0000});
    end
    tx_error = 1'b1;
    tick();
    tx_error = 1'b0;
    check("abort_active_on_error", {busy, mb_ack, mb_aborted}, {1'b0, 4'b0000, 4'b0010});
    mb_req = '0;
    mb_abort_req = '0;

    // Abort while waiting for the bus is immediate
    mb_req = 4'b0010;
    bus_idle = 1'b0;
    starts = 0;
    for (int k = 0; k < 9; k++) begin
      tick();
      if (tx_start) starts++;
    end
    check("wait_bus_no_start", {busy, 8'(starts)}, {1'b1, 8'd0});
    mb_abort_req = 4'b0010;
    tick();
    check("wait_bus_abort", {busy, tx_start, mb_ack, mb_aborted}, {1'b0, 1'b0, 4'b0, 4'b0010});
    mb_req = '0;
    mb_abort_req = '0;

    // Request withdrawn while waiting for the bus: silent return to idle
    mb_req = 4'b0001;
    for (int k = 0; k < 9; k++) tick();
    mb_req = '0;
    tick();
    check("wait_bus_withdraw", {busy, tx_start, mb_ack, mb_aborted}, '0);
    bus_idle = 1'b1;

    // Reset during ACTIVE kills even a coincident outcome pulse, then the request restarts
    set_mb(3, {11'h222, 18'h0}, 1'b0, 1'b0, 4'd9);
    mb_req = 4'b1000;
    wait_start("reset_pre", 0, lat);
    reset = 1'b1;
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
    check("reset_mid_active", 64'(all_out), 64'd0);
    reset = 1'b0;
    m_last_sel = 0;
    m_cnt = 0;
    start_and_done("reset_restart", 3);

    // Randomized traffic against the transaction model
    mb_req = '0;
    mb_abort_req = '0;
    for (int t = 0; t < 150; t++) begin
      for (int i = 0; i < NMB; i++) begin
        if (!mb_req[i] && $urandom_range(0, 2) == 0) begin
          hi = 11'h0FF + 11'($urandom_range(0, 2));
          set_mb(i, {hi, 18'($urandom)}, 1'($urandom), 1'($urandom), 4'($urandom));
          mb_req[i] = 1'b1;
        end
      end
      if (mb_req == '0) begin
        w = $urandom_range(0, NMB - 1);
        set_mb(w, {11'h0FF, 18'($urandom)}, 1'($urandom), 1'($urandom), 4'($urandom));
        mb_req[w] = 1'b1;
      end
      w = ref_winner();
      model_select(w);
      wait_start("rnd_start", $urandom_range(0, 9), lat);
      if (lat < 0) begin
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_last_sel = 0;
        m_cnt = 0;
        continue;
      end
      check_sel("rnd_sel", w);
      ab = ($urandom_range(0, 5) == 0);
      mb_abort_req[w] = ab;
      n_hold = $urandom_range(0, 2);
      for (int k = 0; k < n_hold; k++) begin
        tick();
        check("rnd_hold", {busy, tx_start, mb_ack, mb_aborted}, {1'b1, 1'b0, 4'b0, 4'b0});
      end
      r = $urandom_range(0, 4);
      d = (r == 0 || r == 3);
      tx_done  = d;
      tx_lost  = (r == 1 || r == 3 || r == 4);
      tx_error = (r == 2 || r == 3 || r == 4);
      tick();
      tx_done = 1'b0;
      tx_lost = 1'b0;
      tx_error = 1'b0;
      exp_ack = '0;
      exp_abt = '0;
      if (d) begin
        exp_ack = NMB'(1 << w);
        m_cnt = 0;
      end else begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (ab || m_cnt >= MAX_RETRY) begin
          exp_abt = NMB'(1 << w);
          m_cnt = 0;
        end
      end
      check("rnd_outcome", {busy, mb_ack, mb_aborted}, {1'b0, exp_ack, exp_abt});
      if (exp_ack != '0 || exp_abt != '0) begin
        mb_req[w] = 1'b0;
        mb_abort_req[w] = 1'b0;
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/can_tx_scheduler.md
Name: can_tx_scheduler

Overview:
- Arbiter/sequencer in front of the CAN transmit encapsulation unit.
- Scans NMB transmit mailboxes and picks the pending one with the highest CAN bus priority. Latches that mailbox's identifier, extended flag, remote flag and DLC into stable registers that drive the encapsulation unit.
- Starts the LLC transmission, then on the outcome acknowledges, retries or aborts the mailbox.

Parameters:
- NMB, 4, number of transmit mailboxes (2..8).
- IDXW, 2, index width, equal to ceil(log2(NMB)).
- MAX_RETRY, 15, failed attempts allowed before abort (1..255). 0 means unlimited.

Ports:
- clock  in  1  main clock.
- reset  in  1  synchronous, active-high reset.
- mb_req  in  NMB  transmit request per mailbox, level, held by mailbox until ack/abort.
- mb_abort_req  in  NMB  CPU abort request per mailbox, level.
- mb_id  in  NMB*29  identifiers; mailbox i at [29*i+28:29*i].
- mb_ext  in  NMB  extended-frame flag per mailbox.
- mb_rem  in  NMB  remote-frame flag per mailbox.
- mb_dlc  in  NMB*4  DLC per mailbox; mailbox i at [4*i+3:4*i].
- bus_idle  in  1  LLC ready to start a frame.
- tx_done  in  1  pulse: frame sent and acknowledged.
- tx_lost  in  1  pulse: arbitration lost.
- tx_error  in  1  pulse: error frame during transmit.
- enc_identifier  out  29  to encapsulation identifier.
- enc_extended  out  1  to encapsulation extended.
- enc_remote  out  1  to encapsulation remote.
- enc_datalen  out  4  to encapsulation datalen.
- tx_start  out  1  one-cycle pulse: start frame (drives LLC activ capture).
- tx_sel  out  IDXW  index of the selected mailbox.
- mb_ack  out  NMB  one-cycle pulse: mailbox transmitted.
- mb_aborted  out  NMB  one-cycle pulse: mailbox dropped.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: every output is 0, FSM is IDLE, retry counter is 0, scan index is 0.
- Arbitration key per mailbox, 32 bits, lower value wins. Fields from MSB to LSB:
  - id[28:18].
  - ext ? 1 : rem (SRR for extended, RTR for standard).
  - ext.
  - ext ? id[17:0] : 18'd0.
  - ext ? rem : 0.
- Equal keys: the lower index wins.
- IDLE: if mb_req is nonzero, go to SCAN with index 0 and best_valid 0.
- SCAN: one mailbox per cycle.
  - If mb_req[idx] is set and (best_valid is 0 or key < best_key), record best_idx and best_key and set best_valid.
  - After idx = NMB-1, go to LOAD if best_valid is set, otherwise IDLE.
  - Scan takes exactly NMB cycles.
- LOAD: register the selected mailbox's fields into the enc_* outputs and tx_sel, then go to WAIT_BUS.
  - enc_* outputs change only in LOAD and hold stable until the next LOAD.
- WAIT_BUS:
  - If mb_req[sel] has dropped, go to IDLE with no pulse.
  - Else if mb_abort_req[sel] is set, pulse mb_aborted[sel] and go to IDLE.
  - Else if bus_idle is set, pulse tx_start for one cycle and go to ACTIVE.
- ACTIVE: wait for an outcome. Priority when pulses coincide: tx_done > tx_error > tx_lost.
  - tx_done: pulse mb_ack[sel], clear the retry counter, go to IDLE.
  - tx_lost or tx_error: increment the retry counter (saturating at 255).
    - If mb_abort_req[sel] is set, or MAX_RETRY != 0 and the new count >= MAX_RETRY: pulse mb_aborted[sel], clear the counter, go to IDLE.
    - Otherwise go to IDLE, which triggers a full rescan so a higher-priority newcomer can preempt.
  - The retry counter tracks only the mailbox last attempted. A different selection in LOAD clears it.
  - mb_abort_req during ACTIVE with no outcome is deferred; the frame on the bus is never cut.
- Latency: request in an empty system → tx_start = NMB+3 cycles, given bus_idle.
- Changes to mb_req during SCAN are sampled per index as scanned. Late requests wait for the next scan.
- Reset asserted in any state: next cycle is IDLE with every output 0, including in-flight pulses.
- Unused upper indices when NMB < 2^IDXW are never selected.

Test Plan:
- Single std request: mb_req=0001, id[28:18]=0x123, dlc=8, bus_idle=1 → tx_start at cycle 7 after request; enc_identifier[28:18]=0x123, enc_datalen=8; tx_done → mb_ack=0001 pulse, busy=0 next cycle.
- Priority: mb1 std id 0x100, mb2 std id 0x0FF, mb3 ext base 0x0FF → tx_sel=2. After ack, tx_sel=3, then tx_sel=1.
- Equal keys: mb0 and mb3 both std 0x200 data frames → mb0 first. Std data vs std remote with the same id → data first.
- Retry limit MAX_RETRY=3: three tx_lost pulses → three tx_start pulses, then mb_aborted[sel] on the 3rd loss, no 4th start.
- Abort: mb_abort_req[sel]=1 while ACTIVE → no abort until tx_error, then mb_aborted pulse. Same request in WAIT_BUS with bus_idle=0 → immediate mb_aborted pulse.
- Reset mid-ACTIVE → all outputs 0 next cycle. After reset release, pending request rescans and tx_start recurs with NMB+3 latency.
